// File: rtl/mult_block_host.sv
// mult_block_host
// ---------------
// Self-test master for the block multiplier. A run fills the multiplier
// with BLOCK_DEPTH operand pairs (idx, k), then requests a block read-back
// and checks every returned product against idx*k computed locally.
// A watchdog aborts the read-back if the responder goes quiet.
//
// Ports:
//   CLK, rst         rising-edge clock, synchronous active-high reset
//   start, k         run request (accepted in IDLE only) and second operand
//   RDY_mult         multiplier accepts a pair this cycle
//   VALID_memVal     memVal_data carries a stored product this cycle
//   memVal_data      returned product
//   EN_mult          pair on mult_input0/1 is offered
//   mult_input0/1    operand n (pair index) / operand k (latched)
//   EN_blockRead     block read-back request
//   busy, done       run in progress / one-cycle end-of-run pulse
//   pass, timeout    run verdict / watchdog abort (sticky until next start)
//   err_count        product mismatches, saturating at 64
//   checksum         sum of accepted read-back words, mod 2^32
module mult_block_host #(
  parameter int BLOCK_DEPTH = 64,
  parameter int TIMEOUT     = 256
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] k,
  input  logic        RDY_mult,
  input  logic        VALID_memVal,
  input  logic [31:0] memVal_data,
  output logic        EN_mult,
  output logic [15:0] mult_input0,
  output logic [15:0] mult_input1,
  output logic        EN_blockRead,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [6:0]  err_count,
  output logic [31:0] checksum
);

  localparam int IDX_W = $clog2(BLOCK_DEPTH);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_DEPTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
  localparam logic [6:0]       ERR_SAT  = 7'd64;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_REQ    = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      k_q, k_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             en_mult_q, en_mult_d;
  logic             en_br_q, en_br_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [6:0]       err_q, err_d;
  logic [31:0]      sum_q, sum_d;
  logic [31:0]      expected_s;

  // Full 32-bit product of zero-extended operands.
  function automatic logic [31:0] product_f(input logic [IDX_W-1:0] n,
                                            input logic [15:0] kv);
    return 32'(n) * 32'(kv);
  endfunction

  // Next-state logic for the run sequencer, counters and registered outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    k_d        = k_q;
    wd_d       = wd_q;
    en_mult_d  = en_mult_q;
    en_br_d    = en_br_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    sum_d      = sum_q;
    expected_s = product_f(idx_q, k_q);

    case (state_q)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped on purpose.
        if (start && !done_q) begin
          k_d       = k;
          err_d     = 7'd0;
          sum_d     = 32'd0;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
          idx_d     = '0;
          wd_d      = '0;
          en_mult_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_FILL;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FILL: begin
        // Without RDY_mult the same pair stays on the bus.
        if (en_mult_q && RDY_mult) begin
          if (idx_q == IDX_LAST) begin
            idx_d     = '0;
            en_mult_d = 1'b0;
            en_br_d   = 1'b1;
            wd_d      = '0;
            state_d   = S_REQ;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          en_mult_d = 1'b1;
        end
      end

      S_REQ, S_DRAIN: begin
        // The beat that ends REQ is data beat 0, so both states share checking.
        if (VALID_memVal) begin
          wd_d    = '0;
          en_br_d = 1'b0;
          sum_d   = sum_q + memVal_data;
          if ((memVal_data != expected_s) && (err_q != ERR_SAT)) begin
            err_d = err_q + 7'd1;
          end else begin
            err_d = err_q;
          end
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_DRAIN;
          end
        end else if (wd_q == WD_LAST) begin
          wd_d      = '0;
          idx_d     = '0;
          timeout_d = 1'b1;
          en_br_d   = 1'b0;
          state_d   = S_FINISH;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end

      S_FINISH: begin
        pass_d  = (err_q == 7'd0) && !timeout_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        en_mult_d = 1'b0;
        en_br_d   = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      k_q       <= 16'd0;
      wd_q      <= '0;
      en_mult_q <= 1'b0;
      en_br_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= 7'd0;
      sum_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      k_q       <= k_d;
      wd_q      <= wd_d;
      en_mult_q <= en_mult_d;
      en_br_q   <= en_br_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      sum_q     <= sum_d;
    end
  end

  assign EN_mult      = en_mult_q;
  assign mult_input0  = 16'(idx_q);
  assign mult_input1  = k_q;
  assign EN_blockRead = en_br_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign err_count    = err_q;
  assign checksum     = sum_q;

endmodule

// File: tb/tb_mult_block_host.sv
module tb_mult_block_host;

  localparam int DEPTH = 64;

  logic        CLK;
  logic        rst;
  logic        start;
  logic [15:0] k;
  logic        RDY_mult;
  logic        VALID_memVal;
  logic [31:0] memVal_data;
  logic        EN_mult;
  logic [15:0] mult_input0;
  logic [15:0] mult_input1;
  logic        EN_blockRead;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [6:0]  err_count;
  logic [31:0] checksum;

  int tests_run = 0;
  int failed    = 0;

  logic [31:0] mem [0:DEPTH-1];

  mult_block_host #(.BLOCK_DEPTH(DEPTH), .TIMEOUT(16)) dut (
    .CLK(CLK), .rst(rst), .start(start), .k(k), .RDY_mult(RDY_mult),
    .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
    .EN_mult(EN_mult), .mult_input0(mult_input0), .mult_input1(mult_input1),
    .EN_blockRead(EN_blockRead), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .checksum(checksum)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: sum over the block of the words the responder returns.
  function automatic logic [31:0] model_sum(input logic [15:0] kk, input int bad,
                                            input logic [31:0] bv);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < DEPTH; i++) s = s + ((i == bad) ? bv : 32'(i) * 32'(kk));
    return s;
  endfunction

  function automatic int model_err(input logic [15:0] kk, input int bad,
                                   input logic [31:0] bv);
    int e;
    e = 0;
    for (int i = 0; i < DEPTH; i++) if (i == bad && bv != 32'(i) * 32'(kk)) e++;
    return e;
  endfunction

  // Plays both multiplier ports: captures pairs, then returns the stored products.
  task automatic drive_run(
    input logic [15:0] kk, input int stall_lo, input int stall_hi,
    input int bad_beat, input logic [31:0] bad_val,
    input bit gaps, input int extra, input bit respond, input bit poke,
    output int fill_cycles, output int pair_err, output int hold10,
    output int br_cycles, output int done_cnt,
    output logic [6:0] o_err, output logic [31:0] o_sum,
    output logic o_pass, output logic o_to, output logic busy_after, output bit hung);
    int nxt, beats, gap_run, post;
    bit started, seen_done;
    fill_cycles = 0; pair_err = 0; hold10 = 0; br_cycles = 0; done_cnt = 0;
    o_err = 7'd0; o_sum = 32'd0; o_pass = 1'b0; o_to = 1'b0; busy_after = 1'b0; hung = 1'b0;
    nxt = 0; beats = 0; gap_run = 0; post = 0; started = 1'b0; seen_done = 1'b0;
    @(negedge CLK); k = kk; start = 1'b1; RDY_mult = 1'b1; VALID_memVal = 1'b0;
    @(negedge CLK); start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (EN_mult !== 1'b1) break;
      RDY_mult = (fill_cycles >= stall_lo && fill_cycles <= stall_hi) ? 1'b0 : 1'b1;
      if (poke && fill_cycles == 5) begin start = 1'b1; k = ~kk; end
      if (mult_input0 == 16'd10) hold10++;
      if (RDY_mult) begin
        if (mult_input0 !== 16'(nxt) || mult_input1 !== kk) pair_err++;
        mem[mult_input0[5:0]] = 32'(mult_input0) * 32'(mult_input1);
        nxt++;
      end
      fill_cycles++;
      @(negedge CLK); start = 1'b0;
    end
    RDY_mult = 1'b1;
    if (nxt != DEPTH) pair_err++;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (seen_done) post++;
      if (seen_done && post >= 2 && (!respond || beats >= DEPTH + extra)) break;
      if (EN_blockRead === 1'b1) begin br_cycles++; started = 1'b1; end
      if (done === 1'b1) begin
        done_cnt++;
        if (!seen_done) begin
          o_err = err_count; o_sum = checksum; o_pass = pass; o_to = timeout;
          seen_done = 1'b1;
          if (poke) begin start = 1'b1; k = 16'hFFFF; end
        end
      end
      if (post == 1) busy_after = busy;
      if (respond && started && beats < DEPTH + extra) begin
        if (gaps && gap_run < 3 && $urandom_range(0, 3) == 0) begin
          VALID_memVal = 1'b0; gap_run++;
        end else begin
          VALID_memVal = 1'b1;
          memVal_data = (beats == bad_beat) ? bad_val :
                        ((beats < DEPTH) ? mem[beats] : $urandom);
          beats++; gap_run = 0;
        end
      end else begin
        VALID_memVal = 1'b0;
      end
      @(negedge CLK); start = 1'b0;
    end
    VALID_memVal = 1'b0; start = 1'b0;
    if (!seen_done) hung = 1'b1;
    @(negedge CLK);
  endtask

  int fc, pe, h10, brc, dc;
  logic [6:0] oe;
  logic [31:0] os;
  logic op, ot, ba;
  bit hg;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; k = 16'h1234; RDY_mult = 1'b1;
    VALID_memVal = 1'b1; memVal_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge CLK);
    tests_run++;
    if ({EN_mult, mult_input0, mult_input1, EN_blockRead, busy, done, pass, timeout,
         err_count, checksum} !== 77'd0) begin
      failed++;
      $display("FAIL reset_outputs: got busy=%b en=%b sum=%h, required all zero",
               busy, EN_mult, checksum);
    end
    rst = 1'b0; VALID_memVal = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_nominal();
    drive_run(16'd2, 1000, 1000, -1, 32'd0, 1'b0, 0, 1'b1, 1'b0,
              fc, pe, h10, brc, dc, oe, os, op, ot, ba, hg);
    tests_run++; if (hg || dc !== 1) begin failed++; $display("FAIL nominal_done: got %0d pulses (hung=%0d), required 1", dc, hg); end
    tests_run++; if (fc !== 64 || pe !== 0) begin failed++; $display("FAIL nominal_fill: got %0d EN cycles %0d pair errors, required 64 and 0", fc, pe); end
    tests_run++; if (brc !== 1) begin failed++; $display("FAIL nominal_req: got %0d EN_blockRead cycles, required 1", brc); end
    tests_run++; if (os !== 32'd4032) begin failed++; $display("FAIL nominal_sum: got %0d, required 4032", os); end
    tests_run++; if (op !== 1'b1 || oe !== 7'd0 || ot !== 1'b0) begin failed++; $display("FAIL nominal_verdict: got pass=%b err=%0d to=%b, required 1 0 0", op, oe, ot); end
  endtask

  task automatic test_stall();
    logic [15:0] kk;
    kk = 16'($urandom);
    drive_run(kk, 10, 12, -1, 32'd0, 1'b0, 0, 1'b1, 1'b0,
              fc, pe, h10, brc, dc, oe, os, op, ot, ba, hg);
    tests_run++; if (h10 !== 4) begin failed++; $display("FAIL stall_hold: got pair 10 for %0d cycles, required 4", h10); end
    tests_run++; if (pe !== 0 || fc !== 67) begin failed++; $display("FAIL stall_pairs: got %0d pair errors %0d cycles, required 0 and 67", pe, fc); end
    tests_run++; if (op !== 1'b1 || os !== model_sum(kk, -1, 32'd0)) begin failed++; $display("FAIL stall_result: got pass=%b sum=%h, required 1 %h", op, os, model_sum(kk, -1, 32'd0)); end
  endtask

  task automatic test_corrupt();
    drive_run(16'd3, 1000, 1000, 5, 32'hDEADBEEF, 1'b0, 0, 1'b1, 1'b0,
              fc, pe, h10, brc, dc, oe, os, op, ot, ba, hg);
    tests_run++; if (oe !== 7'd1) begin failed++; $display("FAIL corrupt_err: got %0d, required 1", oe); end
    tests_run++; if (op !== 1'b0) begin failed++; $display("FAIL corrupt_pass: got %b, required 0", op); end
    tests_run++; if (os !== 32'd6048 - 32'd15 + 32'hDEADBEEF) begin failed++; $display("FAIL corrupt_sum: got %h, required %h", os, 32'd6048 - 32'd15 + 32'hDEADBEEF); end
  endtask

  task automatic test_timeout();
    drive_run(16'd1, 1000, 1000, -1, 32'd0, 1'b0, 0, 1'b0, 1'b0,
              fc, pe, h10, brc, dc, oe, os, op, ot, ba, hg);
    tests_run++; if (brc !== 16) begin failed++; $display("FAIL timeout_req_len: got %0d cycles, required 16", brc); end
    tests_run++; if (hg || dc !== 1 || ot !== 1'b1 || op !== 1'b0) begin failed++; $display("FAIL timeout_verdict: got done=%0d to=%b pass=%b, required 1 1 0", dc, ot, op); end
    tests_run++; if (timeout !== 1'b1) begin failed++; $display("FAIL timeout_sticky: got %b, required 1", timeout); end
  endtask

  task automatic test_reset_mid_fill();
    int dones;
    dones = 0;
    @(negedge CLK); k = 16'd7; start = 1'b1; RDY_mult = 1'b1;
    @(negedge CLK); start = 1'b0;
    repeat (20) @(negedge CLK);
    tests_run++; if (EN_mult !== 1'b1 || mult_input0 !== 16'd20) begin failed++; $display("FAIL midfill_progress: got en=%b idx=%0d, required 1 20", EN_mult, mult_input0); end
    rst = 1'b1;
    @(negedge CLK); rst = 1'b0;
    tests_run++;
    if ({EN_mult, mult_input0, mult_input1, EN_blockRead, busy, done, pass, timeout,
         err_count, checksum} !== 77'd0) begin
      failed++;
      $display("FAIL midfill_reset: got en=%b busy=%b idx=%0d, required all zero", EN_mult, busy, mult_input0);
    end
    repeat (6) begin if (done === 1'b1 || busy === 1'b1) dones++; @(negedge CLK); end
    tests_run++; if (dones !== 0) begin failed++; $display("FAIL midfill_quiet: got %0d active cycles, required 0", dones); end
    drive_run(16'd4, 1000, 1000, -1, 32'd0, 1'b0, 0, 1'b1, 1'b0,
              fc, pe, h10, brc, dc, oe, os, op, ot, ba, hg);
    tests_run++; if (op !== 1'b1 || os !== 32'd8064) begin failed++; $display("FAIL midfill_rerun: got pass=%b sum=%0d, required 1 8064", op, os); end
  endtask

  task automatic test_back_to_back();
    drive_run(16'd4, 1000, 1000, -1, 32'd0, 1'b1, 3, 1'b1, 1'b1,
              fc, pe, h10, brc, dc, oe, os, op, ot, ba, hg);
    tests_run++; if (pe !== 0) begin failed++; $display("FAIL b2b_busy_start: got %0d pair errors, required 0", pe); end
    tests_run++; if (op !== 1'b1 || os !== 32'd8064 || checksum !== 32'd8064) begin failed++; $display("FAIL b2b_run1: got pass=%b sum=%0d now=%0d, required 1 8064", op, os, checksum); end
    tests_run++; if (ba !== 1'b0 || dc !== 1) begin failed++; $display("FAIL b2b_done_start: got busy=%b done=%0d, required 0 1", ba, dc); end
    drive_run(16'd6, 1000, 1000, -1, 32'd0, 1'b1, 3, 1'b1, 1'b0,
              fc, pe, h10, brc, dc, oe, os, op, ot, ba, hg);
    tests_run++; if (hg || op !== 1'b1 || os !== 32'd12096 || checksum !== 32'd12096) begin failed++; $display("FAIL b2b_run2: got pass=%b sum=%0d now=%0d, required 1 12096", op, os, checksum); end
  endtask

  task automatic test_random();
    logic [15:0] kk;
    logic [31:0] bv;
    int bad;
    for (int r = 0; r < 4; r++) begin
      kk  = 16'($urandom);
      bad = (r == 0) ? -1 : int'($urandom_range(0, DEPTH - 1));
      bv  = (r == 3) ? 32'(bad) * 32'(kk) : $urandom;
      drive_run(kk, int'($urandom_range(0, 60)), int'($urandom_range(0, 63)), bad, bv,
                1'b1, int'($urandom_range(0, 2)), 1'b1, 1'b0,
                fc, pe, h10, brc, dc, oe, os, op, ot, ba, hg);
      tests_run++;
      if (hg || pe !== 0 || int'(oe) !== model_err(kk, bad, bv) ||
          os !== model_sum(kk, bad, bv) || op !== (model_err(kk, bad, bv) == 0)) begin
        failed++;
        $display("FAIL random_%0d: got err=%0d sum=%h pass=%b, required %0d %h %0d",
                 r, oe, os, op, model_err(kk, bad, bv), model_sum(kk, bad, bv),
                 model_err(kk, bad, bv) == 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k = 16'd0; RDY_mult = 1'b0;
    VALID_memVal = 1'b0; memVal_data = 32'd0;
    test_reset();
    test_nominal();
    test_stall();
    test_corrupt();
    test_timeout();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/mult_block_host.md
Name: mult_block_host

Overview:
- Initiator-side driver for the multiplier's two handshakes: the operand-fill port (EN_mult/RDY_mult) and the block-read port (EN_blockRead/VALID_memVal).
- On start, it generates one block of operand pairs (n, k) and pushes them while the multiplier is ready.
- It then requests the block read-back and checks every returned product against n*k computed locally.
- It reports an error count, a checksum, timeout and pass/fail. It is used as the on-chip self-test master in front of the multiplier.

Parameters:
- BLOCK_DEPTH, 64, pairs per block; must equal the multiplier memory depth (6-bit address space).
- TIMEOUT, 256, maximum cycles in REQ or DRAIN without a VALID_memVal beat before aborting.

Ports:
- CLK  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to run a block; sampled only in IDLE, ignored otherwise.
- k  input  16  constant second operand; latched on accepted start.
- RDY_mult  input  1  multiplier can accept a pair this cycle.
- VALID_memVal  input  1  memVal_data carries a stored product this cycle.
- memVal_data  input  32  returned product.
- EN_mult  output  1  pair on mult_input0/1 is offered.
- mult_input0  output  16  operand n (pair index).
- mult_input1  output  16  operand k (latched).
- EN_blockRead  output  1  block read-back request.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse on entry to IDLE from a run.
- pass  output  1  err_count==0 and no timeout; valid from done until the next accepted start.
- timeout  output  1  run aborted by the watchdog; sticky until the next accepted start.
- err_count  output  7  mismatch count, saturating at 64.
- checksum  output  32  sum of all accepted memVal_data words, mod 2^32.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the counters are cleared. Reset mid-run aborts immediately with no done pulse. Reset wins over every other event in the same cycle.
- States: IDLE, FILL, REQ, DRAIN, FINISH.
- IDLE:
  - start=1 latches k and clears err_count, checksum, timeout, pass and idx, then moves to FILL on the next cycle.
- FILL:
  - EN_mult=1; mult_input0=idx; mult_input1=k_latched.
  - A pair is accepted on any cycle with EN_mult&&RDY_mult, and idx increments on that cycle.
  - While RDY_mult=0 the same pair is held stable with EN_mult=1 (stall, no skip).
  - When pair BLOCK_DEPTH-1 is accepted, EN_mult drops the next cycle, idx clears, and the state moves to REQ.
  - The watchdog does not run in FILL.
- REQ:
  - EN_blockRead=1 is held until the first cycle with VALID_memVal=1, then deasserts the next cycle, and the state moves to DRAIN.
  - The VALID beat that ends REQ is data beat 0 and is checked.
- DRAIN:
  - Every cycle with VALID_memVal=1 is one beat.
  - Each beat compares memVal_data against the 32-bit product idx*k_latched (zero-extended operands, full 32-bit result). A mismatch increments err_count, saturating at 64.
  - Each beat adds memVal_data to checksum with wraparound, then increments idx.
  - VALID gaps are allowed.
  - After beat BLOCK_DEPTH-1 the state moves to FINISH. Further VALID beats are ignored (not counted, not summed).
- Watchdog:
  - Counts consecutive REQ/DRAIN cycles without VALID and clears on each beat.
  - Reaching TIMEOUT sets timeout=1, drops EN_blockRead, and moves to FINISH.
- FINISH:
  - Sets pass = (err_count==0)&&!timeout.
  - Pulses done=1 for one cycle, then returns to IDLE.
- busy=1 from the cycle after start through FINISH.
- start while busy has no effect. start in the same cycle as the done pulse is ignored; a new start is accepted from IDLE on the next cycle.
- Combinational paths: none from inputs to outputs; all outputs are registered.

Test Plan:
- Nominal: k=2, RDY_mult always 1 and an ideal responder -> 64 EN_mult cycles with pairs (0,2)..(63,2). Then done=1, pass=1, err_count=0, checksum=4032.
- Stall: RDY_mult=0 on fill cycles 10-12 -> pair (10,k) is held for 4 cycles, no index is skipped, all 64 pairs are delivered once, and pass=1.
- Corruption: responder returns word 5 as 0xDEADBEEF with k=3 -> err_count=1, pass=0, and checksum = 6048-15+0xDEADBEEF mod 2^32.
- Timeout: TIMEOUT=16, VALID_memVal never asserted -> EN_blockRead is high for exactly 16 cycles, then timeout=1, done pulses, pass=0.
- Reset mid-FILL after 20 pairs -> next cycle EN_mult=0, busy=0, all outputs 0 and no done. A following start with k=4 completes with pass=1 and checksum=8064.
- Back-to-back runs k=4 then k=6 with VALID gaps and 3 extra trailing VALID beats -> both pass=1, checksums 8064 and 12096, and the extra beats are ignored.
